// File: rtl/adder_pkg.sv
// Width constants and operand/sum types shared by the adder and subtractor blocks.
package adder_pkg;

    localparam int ADDER_WIDTH = 4;

    typedef logic [ADDER_WIDTH-1:0] opnd_t;
    typedef logic [ADDER_WIDTH:0]   sum_t;

endpackage

// File: rtl/sub_comb.sv
// Combinational WIDTH+1-bit subtract between pipeline stage 1 and stage 2.
module sub_comb
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic [WIDTH:0]   sum_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH:0]   diff_o,
    output logic             borrow_o
);

    assign diff_o   = sum_i - {1'b0, opnd_i};
    assign borrow_o = (sum_i < {1'b0, opnd_i});

endmodule

// File: rtl/axis_subtractor.sv
// Joins the sum and operand AXI streams and returns (sum - opnd) mod 2^WIDTH through a 2-stage pipeline.
// Define AXIS_SUBTRACTOR_FLAG_EN to add the res_tuser borrow/wrap flag.
module axis_subtractor
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH:0]   sum_tdata,
    input  logic             sum_tvalid,
    output logic             sum_tready,
    input  logic [WIDTH-1:0] opnd_tdata,
    input  logic             opnd_tvalid,
    output logic             opnd_tready,
    output logic [WIDTH-1:0] res_tdata,
    output logic             res_tvalid,
    input  logic             res_tready
`ifdef AXIS_SUBTRACTOR_FLAG_EN
    ,
    output logic             res_tuser
`endif
);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH:0]   s1_sum_q,   s1_sum_d;
    logic [WIDTH-1:0] s1_opnd_q,  s1_opnd_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q,  res_data_d;

    logic             s2_free;
    logic             accept;
    logic             join_fire;
    logic [WIDTH:0]   diff;
    logic             borrow;

    assign s2_free   = !res_valid_q || res_tready;
    assign accept    = (!s1_valid_q || s2_free) && !reset;
    assign join_fire = sum_tvalid && opnd_tvalid && accept;

    // Both readies wait for both valids, so a lone valid never sees ready.
    assign sum_tready  = join_fire;
    assign opnd_tready = join_fire;

    sub_comb #(
        .WIDTH (WIDTH)
    ) u_sub_comb (
        .sum_i    (s1_sum_q),
        .opnd_i   (s1_opnd_q),
        .diff_o   (diff),
        .borrow_o (borrow)
    );

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_sum_d    = s1_sum_q;
        s1_opnd_d   = s1_opnd_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        if (accept) begin
            s1_valid_d = join_fire;
            if (join_fire) begin
                s1_sum_d  = sum_tdata;
                s1_opnd_d = opnd_tdata;
            end
        end
        if (s2_free) begin
            res_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                res_data_d = diff[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_sum_q    <= '0;
            s1_opnd_q   <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sum_q    <= s1_sum_d;
            s1_opnd_q   <= s1_opnd_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    assign res_tvalid = res_valid_q;
    assign res_tdata  = res_data_q;

`ifdef AXIS_SUBTRACTOR_FLAG_EN
    logic res_flag_q, res_flag_d;

    always_comb begin
        res_flag_d = res_flag_q;
        if (s2_free && s1_valid_q) begin
            res_flag_d = borrow || diff[WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res_flag_q <= 1'b0;
        end else begin
            res_flag_q <= res_flag_d;
        end
    end

    assign res_tuser = res_flag_q;
`else
    logic unused_flag_bits;
    assign unused_flag_bits = borrow ^ diff[WIDTH];
`endif

endmodule

// File: tb/tb_axis_subtractor.sv
// Self-checking bench for axis_subtractor: directed cases plus randomized traffic against a queue model.
module tb_axis_subtractor;
    import adder_pkg::*;

    localparam int W = ADDER_WIDTH;

    logic  clk = 1'b0;
    logic  reset;
    sum_t  sum_tdata;
    logic  sum_tvalid, sum_tready;
    opnd_t opnd_tdata;
    logic  opnd_tvalid, opnd_tready;
    opnd_t res_tdata;
    logic  res_tvalid, res_tready;
    logic  obs_flag;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {int data; int flag;} exp_t;
    typedef struct {int cyc; int data; int flag;} out_t;

    exp_t exp_q[$];
    out_t out_log[$];
    int   in_log[$];

    always #5 clk = ~clk;

    axis_subtractor #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .sum_tdata   (sum_tdata),
        .sum_tvalid  (sum_tvalid),
        .sum_tready  (sum_tready),
        .opnd_tdata  (opnd_tdata),
        .opnd_tvalid (opnd_tvalid),
        .opnd_tready (opnd_tready),
        .res_tdata   (res_tdata),
        .res_tvalid  (res_tvalid),
        .res_tready  (res_tready)
`ifdef AXIS_SUBTRACTOR_FLAG_EN
        ,
        .res_tuser   (obs_flag)
`endif
    );

`ifndef AXIS_SUBTRACTOR_FLAG_EN
    assign obs_flag = 1'b0;
`endif

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: every joined pair yields one result, in order.
    int   mdl_diff;
    exp_t mdl_e;
    bit   prev_stall = 0;
    int   held_data, held_flag;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check_eq("hold_valid", res_tvalid, 1);
                check_eq("hold_data", res_tdata, held_data);
                check_eq("hold_flag", obs_flag, held_flag);
            end
            if (sum_tvalid != opnd_tvalid)
                check_eq("lone_valid_ready", {sum_tready, opnd_tready}, 0);
            if (sum_tvalid && opnd_tvalid && sum_tready && opnd_tready) begin
                in_log.push_back(cyc);
                mdl_diff = int'(sum_tdata) - int'(opnd_tdata);
                mdl_e.data = mdl_diff & ((1 << W) - 1);
                mdl_e.flag = (mdl_diff < 0 || mdl_diff >= (1 << W)) ? 1 : 0;
                exp_q.push_back(mdl_e);
            end
            if (res_tvalid && res_tready) begin
                out_log.push_back('{cyc, int'(res_tdata), int'(obs_flag)});
                if (exp_q.size() == 0) begin
                    check_eq("sb_extra_result", res_tvalid, 0);
                end else begin
                    mdl_e = exp_q.pop_front();
                    check_eq("sb_data", res_tdata, mdl_e.data);
`ifdef AXIS_SUBTRACTOR_FLAG_EN
                    check_eq("sb_flag", obs_flag, mdl_e.flag);
`endif
                end
            end
            prev_stall = res_tvalid && !res_tready;
            held_data  = int'(res_tdata);
            held_flag  = int'(obs_flag);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        in_log.delete();
        out_log.delete();
    endtask

    task automatic send(input int s, input int o);
        bit done = 0;
        sum_tdata   = sum_t'(s);
        opnd_tdata  = opnd_t'(o);
        sum_tvalid  = 1'b1;
        opnd_tvalid = 1'b1;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            done = sum_tready && opnd_tready;
        end
        if (!done) check_eq("send_timeout", sum_tready, 1);
        @(posedge clk);
        #1;
        sum_tvalid  = 1'b0;
        opnd_tvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        sum_tvalid = 1'b1; opnd_tvalid = 1'b1;
        sum_tdata = 5; opnd_tdata = 4; res_tready = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_res_tvalid", res_tvalid, 0);
        check_eq("rst_res_tdata", res_tdata, 0);
        check_eq("rst_sum_tready", sum_tready, 0);
        check_eq("rst_opnd_tready", opnd_tready, 0);
`ifdef AXIS_SUBTRACTOR_FLAG_EN
        check_eq("rst_res_tuser", obs_flag, 0);
`endif
        @(posedge clk); #1;
        reset = 1'b0; sum_tvalid = 1'b0; opnd_tvalid = 1'b0;
        idle(2);

        // single transfer
        clear_logs();
        send(5, 4);
        idle(4);
        check_eq("single_count", out_log.size(), 1);
        if (out_log.size() == 1 && in_log.size() == 1) begin
            check_eq("single_data", out_log[0].data, 1);
            check_eq("single_latency", out_log[0].cyc - in_log[0], 2);
`ifdef AXIS_SUBTRACTOR_FLAG_EN
            check_eq("single_flag", out_log[0].flag, 0);
`endif
        end

        // back-to-back streaming
        clear_logs();
        send(5, 4); send(12, 9); send(26, 13);
        idle(4);
        check_eq("b2b_count", out_log.size(), 3);
        if (out_log.size() == 3) begin
            check_eq("b2b_data0", out_log[0].data, 1);
            check_eq("b2b_data1", out_log[1].data, 3);
            check_eq("b2b_data2", out_log[2].data, 13);
            check_eq("b2b_gap01", out_log[1].cyc - out_log[0].cyc, 1);
            check_eq("b2b_gap12", out_log[2].cyc - out_log[1].cyc, 1);
        end

        // backpressure
        clear_logs();
        res_tready = 1'b0;
        send(12, 9); send(26, 13);
        sum_tdata = 7; opnd_tdata = 2; sum_tvalid = 1'b1; opnd_tvalid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("bp_valid", res_tvalid, 1);
            check_eq("bp_data", res_tdata, 3);
            check_eq("bp_stall", sum_tready, 0);
        end
        @(posedge clk); #1;
        res_tready = 1'b1;
        send(7, 2);
        idle(4);
        check_eq("bp_count", out_log.size(), 3);
        if (out_log.size() == 3) begin
            check_eq("bp_out0", out_log[0].data, 3);
            check_eq("bp_out1", out_log[1].data, 13);
            check_eq("bp_out2", out_log[2].data, 5);
        end

        // one-sided valid
        clear_logs();
        sum_tdata = 9; sum_tvalid = 1'b1; opnd_tvalid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_eq("os_sum_tready", sum_tready, 0);
            check_eq("os_opnd_tready", opnd_tready, 0);
        end
        @(posedge clk); #1;
        sum_tvalid = 1'b0;
        idle(3);
        check_eq("os_no_result", out_log.size(), 0);

        // underflow / wrap
        clear_logs();
        send(2, 5); send(26, 3);
        idle(4);
        check_eq("uf_count", out_log.size(), 2);
        if (out_log.size() == 2) begin
            check_eq("uf_data0", out_log[0].data, 13);
            check_eq("uf_data1", out_log[1].data, 7);
`ifdef AXIS_SUBTRACTOR_FLAG_EN
            check_eq("uf_flag0", out_log[0].flag, 1);
            check_eq("uf_flag1", out_log[1].flag, 1);
`endif
        end

        // reset with two results in flight
        clear_logs();
        res_tready = 1'b0;
        send(5, 4); send(12, 9);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_valid", res_tvalid, 0);
        res_tready = 1'b1;
        idle(4);
        check_eq("mid_rst_flushed", out_log.size(), 0);
        clear_logs();
        send(9, 2);
        idle(4);
        check_eq("post_rst_count", out_log.size(), 1);
        if (out_log.size() == 1 && in_log.size() == 1) begin
            check_eq("post_rst_data", out_log[0].data, 7);
            check_eq("post_rst_latency", out_log[0].cyc - in_log[0], 2);
        end

        // randomized traffic
        clear_logs();
        repeat (400) begin
            sum_tvalid  = ($urandom_range(0, 9) < 7);
            opnd_tvalid = ($urandom_range(0, 9) < 7);
            sum_tdata   = sum_t'($urandom_range(0, 31));
            opnd_tdata  = opnd_t'($urandom_range(0, 15));
            res_tready  = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        sum_tvalid = 1'b0; opnd_tvalid = 1'b0; res_tready = 1'b1;
        idle(6);
        check_eq("rand_drained", exp_q.size(), 0);
        check_eq("rand_in_out", out_log.size(), in_log.size());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
